// File: rtl/citadel_pkg.sv
// Shared encodings for the SRAM arbiter slice: FSM states and master ids.
package citadel_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StResp   = 2'd2
  } arb_state_e;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_DMA = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin pick. The loser of the last grant wins a tie.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o
);

  // Single requester wins outright; a tie goes to the master not granted last.
  always_comb begin
    gnt_o = 1'b0;
    unique case (req_i)
      2'b01:   gnt_o = 1'b0;
      2'b10:   gnt_o = 1'b1;
      2'b11:   gnt_o = ~last_i;
      default: gnt_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port SRAM between two native-bus masters, one access at a time.
// Every output is a flop: the SRAM strobe is loaded on grant, ready/rdata/bus_err in RESP.
module mem_arbiter
  import citadel_pkg::*;
#(
  parameter int unsigned SRAM_SIZE = 65536,
  parameter int unsigned AW        = 14
) (
  input  logic          r_clk,
  input  logic          rst_n,
  input  logic          m0_valid,
  input  logic [31:0]   m0_addr,
  input  logic [31:0]   m0_wdata,
  input  logic [3:0]    m0_wstrb,
  output logic          m0_ready,
  output logic [31:0]   m0_rdata,
  input  logic          m1_valid,
  input  logic [31:0]   m1_addr,
  input  logic [31:0]   m1_wdata,
  input  logic [3:0]    m1_wstrb,
  output logic          m1_ready,
  output logic [31:0]   m1_rdata,
  output logic          sram_en,
  output logic [3:0]    sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_wdata,
  input  logic [31:0]   sram_rdata,
  output logic          bus_err
);

  arb_state_e    state_q, state_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic          in_range_q, in_range_d;
  logic          is_write_q, is_write_d;
  logic          sram_en_q, sram_en_d;
  logic [3:0]    sram_we_q, sram_we_d;
  logic [AW-1:0] sram_addr_q, sram_addr_d;
  logic [31:0]   sram_wdata_q, sram_wdata_d;
  logic          m0_ready_q, m0_ready_d;
  logic          m1_ready_q, m1_ready_d;
  logic [31:0]   m0_rdata_q, m0_rdata_d;
  logic [31:0]   m1_rdata_q, m1_rdata_d;
  logic          bus_err_q, bus_err_d;

  logic          arb_gnt;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic [3:0]    sel_wstrb;
  logic          sel_in_range;
  logic [31:0]   resp_data;

  rr_arb2 u_rr_arb2 (
    .req_i  ({m1_valid, m0_valid}),
    .last_i (last_q),
    .gnt_o  (arb_gnt)
  );

  // Mux the winning master's request fields and classify its address.
  always_comb begin
    sel_addr     = (arb_gnt == MASTER_DMA) ? m1_addr  : m0_addr;
    sel_wdata    = (arb_gnt == MASTER_DMA) ? m1_wdata : m0_wdata;
    sel_wstrb    = (arb_gnt == MASTER_DMA) ? m1_wstrb : m0_wstrb;
    sel_in_range = (sel_addr < SRAM_SIZE);
    // Writes and out-of-range reads return zero so no stale word ever leaks out.
    resp_data    = (in_range_q && !is_write_q) ? sram_rdata : 32'h0;
  end

  // Next-state and registered-output logic for the IDLE -> ACCESS -> RESP cycle.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    gnt_d        = gnt_q;
    in_range_d   = in_range_q;
    is_write_d   = is_write_q;
    sram_en_d    = 1'b0;
    sram_we_d    = 4'h0;
    sram_addr_d  = sram_addr_q;
    sram_wdata_d = sram_wdata_q;
    m0_ready_d   = 1'b0;
    m1_ready_d   = 1'b0;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    bus_err_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (m0_valid || m1_valid) begin
          gnt_d        = arb_gnt;
          last_d       = arb_gnt;
          in_range_d   = sel_in_range;
          is_write_d   = |sel_wstrb;
          sram_en_d    = sel_in_range;
          sram_we_d    = sel_in_range ? sel_wstrb : 4'h0;
          sram_addr_d  = sel_addr[AW+1:2];
          sram_wdata_d = sel_wdata;
          state_d      = StAccess;
        end
      end
      StAccess: begin
        // SRAM strobe is live this cycle; its registered data lands during RESP.
        state_d = StResp;
      end
      StResp: begin
        bus_err_d = ~in_range_q;
        if (gnt_q == MASTER_DMA) begin
          m1_ready_d = 1'b1;
          m1_rdata_d = resp_data;
        end else begin
          m0_ready_d = 1'b1;
          m0_rdata_d = resp_data;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge r_clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_q       <= MASTER_DMA;
      gnt_q        <= MASTER_CPU;
      in_range_q   <= 1'b0;
      is_write_q   <= 1'b0;
      sram_en_q    <= 1'b0;
      sram_we_q    <= 4'h0;
      sram_addr_q  <= '0;
      sram_wdata_q <= 32'h0;
      m0_ready_q   <= 1'b0;
      m1_ready_q   <= 1'b0;
      m0_rdata_q   <= 32'h0;
      m1_rdata_q   <= 32'h0;
      bus_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      in_range_q   <= in_range_d;
      is_write_q   <= is_write_d;
      sram_en_q    <= sram_en_d;
      sram_we_q    <= sram_we_d;
      sram_addr_q  <= sram_addr_d;
      sram_wdata_q <= sram_wdata_d;
      m0_ready_q   <= m0_ready_d;
      m1_ready_q   <= m1_ready_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      bus_err_q    <= bus_err_d;
    end
  end

  assign sram_en    = sram_en_q;
  assign sram_we    = sram_we_q;
  assign sram_addr  = sram_addr_q;
  assign sram_wdata = sram_wdata_q;
  assign m0_ready   = m0_ready_q;
  assign m1_ready   = m1_ready_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural registered-read SRAM.
module tb_mem_arbiter;

  localparam int unsigned AW = 14;

  logic          r_clk;
  logic          rst_n;
  logic          m0_valid, m1_valid;
  logic [31:0]   m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]    m0_wstrb, m1_wstrb;
  logic          m0_ready, m1_ready;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;
  logic          bus_err;

  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [31:0]   pl_data;
  logic [31:0]   mem [0:(1<<AW)-1];

  int n_checks;
  int n_pass;

  mem_arbiter #(
    .SRAM_SIZE (65536),
    .AW        (AW)
  ) dut (
    .r_clk      (r_clk),
    .rst_n      (rst_n),
    .m0_valid   (m0_valid),
    .m0_addr    (m0_addr),
    .m0_wdata   (m0_wdata),
    .m0_wstrb   (m0_wstrb),
    .m0_ready   (m0_ready),
    .m0_rdata   (m0_rdata),
    .m1_valid   (m1_valid),
    .m1_addr    (m1_addr),
    .m1_wdata   (m1_wdata),
    .m1_wstrb   (m1_wstrb),
    .m1_ready   (m1_ready),
    .m1_rdata   (m1_rdata),
    .sram_en    (sram_en),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata),
    .bus_err    (bus_err)
  );

  initial r_clk = 1'b0;
  always #5 r_clk = ~r_clk;

  // SRAM model: byte-enabled writes, registered read data one cycle after the strobe.
  always @(posedge r_clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (sram_en) begin
      for (int b = 0; b < 4; b++) begin
        if (sram_we[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end
      if (sram_we == 4'h0) sram_rdata <= mem[sram_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge r_clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick();
    pl_en   = 1'b0;
  endtask

  // One transaction on one master; valid is dropped as soon as ready is seen.
  task automatic run_txn(input logic m, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] ws, output logic [31:0] rd, output logic err,
                         output int lat);
    rd  = 32'h0;
    err = 1'b0;
    lat = 0;
    if (m) begin
      m1_valid = 1'b1; m1_addr = a; m1_wdata = wd; m1_wstrb = ws;
    end else begin
      m0_valid = 1'b1; m0_addr = a; m0_wdata = wd; m0_wstrb = ws;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      lat++;
      if ((m && m1_ready) || (!m && m0_ready)) begin
        rd  = m ? m1_rdata : m0_rdata;
        err = bus_err;
        break;
      end
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    tick();
  endtask

  logic [31:0] rd;
  logic        err;
  int          lat;
  int          order [6];
  int          when  [6];
  int          cnt;
  int          m0_before;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    pl_en    = 1'b0;
    pl_addr  = '0;
    pl_data  = 32'h0;
    m0_valid = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
    sram_rdata = 32'h0;

    preload(14'h0040, 32'hDEADBEEF);
    preload(14'h0081, 32'hAABBCCDD);
    preload(14'h0000, 32'h11111111);
    preload(14'h0001, 32'h22222222);
    tick();
    check("rst_sram_en", {31'b0, sram_en}, 32'h0);
    check("rst_m0_ready", {31'b0, m0_ready}, 32'h0);
    check("rst_m1_ready", {31'b0, m1_ready}, 32'h0);
    check("rst_bus_err", {31'b0, bus_err}, 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: m0 read of word 0x40, cycle by cycle.
    m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
    tick();
    check("t1_en_n1", {31'b0, sram_en}, 32'h1);
    check("t1_addr_n1", {18'b0, sram_addr}, 32'h40);
    check("t1_we_n1", {28'b0, sram_we}, 32'h0);
    tick();
    check("t1_en_n2", {31'b0, sram_en}, 32'h0);
    check("t1_ready_n2", {31'b0, m0_ready}, 32'h0);
    tick();
    check("t1_ready_n3", {31'b0, m0_ready}, 32'h1);
    check("t1_rdata", m0_rdata, 32'hDEADBEEF);
    check("t1_err", {31'b0, bus_err}, 32'h0);
    check("t1_m1_ready", {31'b0, m1_ready}, 32'h0);
    m0_valid = 1'b0;
    tick();
    check("t1_ready_drop", {31'b0, m0_ready}, 32'h0);

    // 2: m1 partial write then read-back.
    m1_valid = 1'b1; m1_addr = 32'h204; m1_wdata = 32'h12345678; m1_wstrb = 4'b0011;
    tick();
    check("t2_en", {31'b0, sram_en}, 32'h1);
    check("t2_we", {28'b0, sram_we}, 32'h3);
    check("t2_addr", {18'b0, sram_addr}, 32'h81);
    check("t2_wdata", sram_wdata, 32'h12345678);
    tick();
    tick();
    check("t2_ready", {31'b0, m1_ready}, 32'h1);
    check("t2_wr_rdata", m1_rdata, 32'h0);
    m1_valid = 1'b0;
    tick();
    run_txn(1'b1, 32'h204, 32'h0, 4'h0, rd, err, lat);
    check("t2_readback", rd, 32'hAABB5678);
    check("t2_lat", lat, 32'd3);

    // 3: both masters request continuously; grants alternate, 3 cycles apart.
    m0_valid = 1'b1; m0_addr = 32'h0; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'h4; m1_wstrb = 4'h0;
    cnt = 0;
    for (int c = 1; c <= 30 && cnt < 6; c++) begin
      tick();
      if (m0_ready || m1_ready) begin
        order[cnt] = m1_ready ? 1 : 0;
        when[cnt]  = c;
        if (m0_ready && m1_ready) check("t3_both_ready", 32'h1, 32'h0);
        cnt++;
        if (cnt == 6) begin
          m0_valid = 1'b0;
          m1_valid = 1'b0;
        end
      end
    end
    check("t3_count", cnt, 32'd6);
    for (int k = 0; k < cnt; k++) begin
      check($sformatf("t3_order%0d", k), order[k], k % 2);
      check($sformatf("t3_when%0d", k), when[k], 3 * (k + 1));
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    tick();

    // 4: out-of-range read returns zero with bus_err and never strobes the SRAM.
    m0_valid = 1'b1; m0_addr = 32'h0001_0000; m0_wstrb = 4'h0;
    tick();
    check("t4_en_n1", {31'b0, sram_en}, 32'h0);
    tick();
    check("t4_en_n2", {31'b0, sram_en}, 32'h0);
    tick();
    check("t4_ready", {31'b0, m0_ready}, 32'h1);
    check("t4_rdata", m0_rdata, 32'h0);
    check("t4_err", {31'b0, bus_err}, 32'h1);
    m0_valid = 1'b0;
    tick();
    check("t4_err_drop", {31'b0, bus_err}, 32'h0);

    // 5: reset during an m1 write's ACCESS cycle.
    m1_valid = 1'b1; m1_addr = 32'h300; m1_wdata = 32'hCAFEF00D; m1_wstrb = 4'hF;
    tick();
    check("t5_access_en", {31'b0, sram_en}, 32'h1);
    rst_n    = 1'b0;
    m1_valid = 1'b0;
    tick();
    check("t5_rst_m1_ready", {31'b0, m1_ready}, 32'h0);
    check("t5_rst_en", {31'b0, sram_en}, 32'h0);
    check("t5_rst_we", {28'b0, sram_we}, 32'h0);
    check("t5_rst_addr", {18'b0, sram_addr}, 32'h0);
    check("t5_rst_wdata", sram_wdata, 32'h0);
    check("t5_rst_m0_rdata", m0_rdata, 32'h0);
    check("t5_rst_m1_rdata", m1_rdata, 32'h0);
    check("t5_rst_err", {31'b0, bus_err}, 32'h0);
    tick();
    check("t5_rst_m1_ready2", {31'b0, m1_ready}, 32'h0);
    rst_n    = 1'b1;
    m0_valid = 1'b1; m0_addr = 32'h8; m0_wstrb = 4'h0;
    m1_valid = 1'b1; m1_addr = 32'hC; m1_wstrb = 4'h0;
    tick();
    check("t5_tie_addr", {18'b0, sram_addr}, 32'h2);
    tick();
    tick();
    check("t5_tie_m0_ready", {31'b0, m0_ready}, 32'h1);
    check("t5_tie_m1_ready", {31'b0, m1_ready}, 32'h0);
    m0_valid = 1'b0;
    tick();
    tick();
    tick();
    check("t5_m1_after", {31'b0, m1_ready}, 32'h1);
    m1_valid = 1'b0;
    tick();

    // 6: m0 streams reads; m1 arrives mid-access and must get the next grant.
    m0_valid = 1'b1; m0_addr = 32'h10; m0_wstrb = 4'h0;
    tick();
    m1_valid = 1'b1; m1_addr = 32'h14; m1_wstrb = 4'h0;
    m0_before = 0;
    lat = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (m0_ready) m0_before++;
      if (m1_ready) begin
        lat = c;
        break;
      end
    end
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    check("t6_m1_lat", lat, 32'd5);
    check("t6_m0_before", m0_before, 32'd1);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
